display_arbiter: RTL and testbench

Time-slicing arbiter that shares the single 4-digit seven-segment display between four requesters. Each requester presents a 16-bit hex text word. The arbiter grants the display to one requester at a time and drives the granted word onto the 16-bit `text` input of the `display` block. Grants rotate round-robin, with a guaranteed minimum dwell time per owner under contention.

---
 rtl/display_arbiter_if.sv | 33 +++
 rtl/display_arbiter.sv | 137 +++++++++++++
 tb/tb_display_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/display_arbiter_if.sv
// Request/grant bus between the display requesters and the display arbiter.
interface display_arbiter_if;
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned TEXT_W = 16;
    localparam int unsigned IDX_W  = 2;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*TEXT_W-1:0] text_in;
    logic [N_REQ-1:0]        gnt;
    logic [IDX_W-1:0]        owner;
    logic                    busy;
    logic [TEXT_W-1:0]       text;

    // Requester side: presents requests and words, observes the grant.
    modport master (
        output req,
        output text_in,
        input  gnt,
        input  owner,
        input  busy,
        input  text
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  text_in,
        output gnt,
        output owner,
        output busy,
        output text
    );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin, time-sliced owner selection for the shared 4-digit display.
// The owner keeps the display for DWELL cycles while others wait, indefinitely
// when nobody else asks, and loses it as soon as it drops its request.
module display_arbiter #(
    parameter int unsigned DWELL_W    = 24,
    parameter int unsigned DWELL      = 10_000_000,
    parameter logic [15:0] BLANK_TEXT = 16'h0000
) (
    input  logic              clk,
    input  logic              arst_n,
    display_arbiter_if.slave  bus
);
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned TEXT_W = 16;
    localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    last_q,  last_d;
    logic [DWELL_W-1:0]  cnt_q,   cnt_d;
    logic [N_REQ-1:0]    gnt_q,   gnt_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                busy_q,  busy_d;
    logic [TEXT_W-1:0]   text_q,  text_d;

    logic                found_other;
    logic [IDX_W-1:0]    other_idx;
    logic [IDX_W-1:0]    cand;
    logic                grant;
    logic [IDX_W-1:0]    grant_idx;

    // First requester after last in rotation order, excluding last itself.
    always_comb begin
        found_other = 1'b0;
        other_idx   = last_q;
        cand        = last_q;
        for (int unsigned i = 1; i < N_REQ; i++) begin
            cand = last_q + IDX_W'(i);
            if (!found_other && bus.req[cand]) begin
                found_other = 1'b1;
                other_idx   = cand;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        text_d    = text_q;
        grant     = 1'b0;
        grant_idx = other_idx;

        case (state_q)
            S_IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                text_d = BLANK_TEXT;
                if (|bus.req) begin
                    grant     = 1'b1;
                    // last itself is the final candidate in the rotation
                    grant_idx = found_other ? other_idx : last_q;
                end
            end
            S_HOLD: begin
                text_d = bus.text_in[{owner_q, 4'b0000} +: TEXT_W];
                cnt_d  = cnt_q + DWELL_W'(1);
                if (!bus.req[owner_q]) begin
                    if (found_other) begin
                        grant = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        text_d  = BLANK_TEXT;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    if (found_other) begin
                        grant = 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (grant) begin
            state_d = S_HOLD;
            last_d  = grant_idx;
            owner_d = grant_idx;
            gnt_d   = N_REQ'(1) << grant_idx;
            busy_d  = 1'b1;
            cnt_d   = '0;
            text_d  = bus.text_in[{grant_idx, 4'b0000} +: TEXT_W];
        end
    end

    // State and output registers; last resets to 3 so requester 0 goes first.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            last_q  <= IDX_W'(3);
            cnt_q   <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            text_q  <= BLANK_TEXT;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            text_q  <= text_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;
    assign bus.text  = text_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: a DWELL=4 instance driven from a vector
// table and a DWELL=2 instance for the round-robin rotation sequence.
module tb_display_arbiter;
    localparam logic [15:0] W0 = 16'h1110;
    localparam logic [15:0] W1 = 16'h2221;
    localparam logic [15:0] W2 = 16'h8602;
    localparam logic [15:0] W3 = 16'h4443;

    logic clk;
    logic arst_n;
    int   checks;
    int   failures;

    display_arbiter_if bus4 ();
    display_arbiter_if bus2 ();

    display_arbiter #(.DWELL_W(24), .DWELL(4), .BLANK_TEXT(16'h0000)) dut4 (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus4.slave)
    );

    display_arbiter #(.DWELL_W(24), .DWELL(2), .BLANK_TEXT(16'h0000)) dut2 (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] t2;
        logic [3:0]  gnt;
        logic        busy;
        logic [1:0]  owner;
        logic [15:0] text;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [15:0] t2);
        bus4.req     = r;
        bus2.req     = r;
        bus4.text_in = {W3, t2, W1, W0};
        bus2.text_in = {W3, t2, W1, W0};
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [3:0] r, input logic [15:0] t2);
        drive(r, t2);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input int n, input logic [3:0] r, input logic [15:0] t2,
                                input logic [3:0] g, input logic b, input logic [1:0] o,
                                input logic [15:0] t);
        vec_t v;
        v.req = r; v.t2 = t2; v.gnt = g; v.busy = b; v.owner = o; v.text = t;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    logic [3:0] rr_gnt [18];
    logic [15:0] words [4];

    initial begin
        checks   = 0;
        failures = 0;
        words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;

        // Reset held with every requester asking
        arst_n = 1'b0;
        drive(4'b1111, W2);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",  16'(bus4.gnt),  16'h0000);
        chk("rst_busy", 16'(bus4.busy), 16'h0000);
        chk("rst_text", bus4.text,      16'h0000);

        arst_n = 1'b1;
        step(4'b1111, W2);
        chk("rel_gnt",  16'(bus4.gnt), 16'h0001);
        chk("rel_text", bus4.text,     W0);
        step(4'b0000, W2);
        chk("rel_idle", 16'(bus4.busy), 16'h0000);

        // Vector table for the DWELL=4 instance; starts IDLE with last=0
        add(1,  4'b0100, W2,      4'b0100, 1'b1, 2'd2, W2);
        add(10, 4'b0100, W2,      4'b0100, 1'b1, 2'd2, W2);
        add(1,  4'b0100, 16'h8603, 4'b0100, 1'b1, 2'd2, 16'h8603);
        add(8,  4'b0100, W2,      4'b0100, 1'b1, 2'd2, W2);
        add(1,  4'b0000, W2,      4'b0000, 1'b0, 2'd0, 16'h0000);
        add(4,  4'b0101, W2,      4'b0001, 1'b1, 2'd0, W0);
        add(4,  4'b0101, W2,      4'b0100, 1'b1, 2'd2, W2);
        add(4,  4'b0101, W2,      4'b0001, 1'b1, 2'd0, W0);
        add(1,  4'b0000, W2,      4'b0000, 1'b0, 2'd0, 16'h0000);
        add(1,  4'b0001, W2,      4'b0001, 1'b1, 2'd0, W0);
        add(1,  4'b1001, W2,      4'b0001, 1'b1, 2'd0, W0);
        add(1,  4'b1000, W2,      4'b1000, 1'b1, 2'd3, W3);
        add(3,  4'b1001, W2,      4'b1000, 1'b1, 2'd3, W3);
        add(1,  4'b1001, W2,      4'b0001, 1'b1, 2'd0, W0);
        add(1,  4'b0000, W2,      4'b0000, 1'b0, 2'd0, 16'h0000);

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].t2);
            chk($sformatf("vec%0d_gnt", i),  16'(bus4.gnt),  16'(vecs[i].gnt));
            chk($sformatf("vec%0d_busy", i), 16'(bus4.busy), 16'(vecs[i].busy));
            chk($sformatf("vec%0d_text", i), bus4.text,      vecs[i].text);
            if (vecs[i].busy)
                chk($sformatf("vec%0d_owner", i), 16'(bus4.owner), 16'(vecs[i].owner));
        end

        // Asynchronous reset while requester 2 owns the display
        step(4'b0100, W2);
        chk("mid_gnt4", 16'(bus4.gnt), 16'h0004);
        chk("mid_gnt2", 16'(bus2.gnt), 16'h0004);
        #1 arst_n = 1'b0;
        #1;
        chk("async_gnt",  16'(bus4.gnt),  16'h0000);
        chk("async_busy", 16'(bus4.busy), 16'h0000);
        chk("async_text", bus4.text,      16'h0000);
        chk("async_own",  16'(bus4.owner), 16'h0000);
        chk("async_gnt2", 16'(bus2.gnt),  16'h0000);

        // Round robin on the DWELL=2 instance, all four then without requester 1
        for (int i = 0; i < 18; i++) rr_gnt[i] = 4'b0000;
        rr_gnt[0]  = 4'b0001; rr_gnt[1]  = 4'b0001;
        rr_gnt[2]  = 4'b0010; rr_gnt[3]  = 4'b0010;
        rr_gnt[4]  = 4'b0100; rr_gnt[5]  = 4'b0100;
        rr_gnt[6]  = 4'b1000; rr_gnt[7]  = 4'b1000;
        rr_gnt[8]  = 4'b0001; rr_gnt[9]  = 4'b0001;
        rr_gnt[10] = 4'b0100; rr_gnt[11] = 4'b0100;
        rr_gnt[12] = 4'b1000; rr_gnt[13] = 4'b1000;
        rr_gnt[14] = 4'b0001; rr_gnt[15] = 4'b0001;
        rr_gnt[16] = 4'b0100; rr_gnt[17] = 4'b0100;

        drive(4'b1111, W2);
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            int o;
            step((i < 10) ? 4'b1111 : 4'b1101, W2);
            o = (rr_gnt[i] == 4'b0001) ? 0 : (rr_gnt[i] == 4'b0010) ? 1 :
                (rr_gnt[i] == 4'b0100) ? 2 : 3;
            chk($sformatf("rr%0d_gnt", i),  16'(bus2.gnt), 16'(rr_gnt[i]));
            chk($sformatf("rr%0d_text", i), bus2.text,     words[o]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
